// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle ops plus iterative MULTU/DIVU behind start/busy/done
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic [WIDTH-1:0]   ResultHi,
    output logic               Zero,
    output logic               Overflow
);
    localparam int CW = SHAMT_W + 1;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_LUI   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_SRA   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;
    localparam logic [3:0] OP_SLT   = 4'd11;
    localparam logic [3:0] OP_SLTU  = 4'd12;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;

    always_comb begin
        add_res = A + B;
        sub_res = A - B;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        case (ALUOperation)
            OP_SLL:  sc_res = A << Shamt;
            OP_SRL:  sc_res = A >> Shamt;
            OP_LUI:  sc_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD: begin
                sc_res = add_res;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_res;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_SRA:  sc_res = $signed(A) >>> Shamt;
            OP_NOR:  sc_res = ~(A | B);
            OP_OR:   sc_res = A | B;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: sc_res = '0;
        endcase
    end

    // acc_hi/acc_lo hold {partial product, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                hi_next = div_diff[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_trial[WIDTH-1:0];
                lo_next = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUResult <= '0;
            ResultHi  <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (ALUOperation == OP_MULTU || ALUOperation == OP_DIVU) begin
                            state  <= RUN;
                            Busy   <= 1'b1;
                            count  <= CW'(WIDTH);
                            is_div <= (ALUOperation == OP_DIVU);
                            acc_hi <= '0;
                            acc_lo <= (ALUOperation == OP_DIVU) ? A : B;
                            opnd   <= (ALUOperation == OP_DIVU) ? B : A;
                        end else begin
                            ALUResult <= sc_res;
                            ResultHi  <= '0;
                            Zero      <= (sc_res == '0);
                            Overflow  <= sc_ovf;
                            Done      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= hi_next;
                    acc_lo <= lo_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= IDLE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        ALUResult <= lo_next;
                        ResultHi  <= hi_next;
                        Zero      <= (lo_next == '0);
                        Overflow  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
